// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter between two byte sources.
// Each source has a private FIFO. A small FSM issues tx_start and follows tx_busy until the frame completes.
module uart_tx_arbiter #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    input  logic       tx_busy,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       grant_id,
    output logic       timeout_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_BUSY = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;

    logic [7:0]    mem     [2][DEPTH];
    logic [7:0]    in_data [2];
    logic [AW-1:0] wr_ptr  [2];
    logic [AW-1:0] rd_ptr  [2];
    logic [CW-1:0] count   [2];
    logic [1:0]    push;
    logic [1:0]    pop;
    logic [1:0]    not_empty;

    logic [1:0]    state;
    logic          rr;
    logic [TW-1:0] timer;
    logic          grant;
    logic          winner;
    logic [7:0]    head;

    assign in_data[0] = req0_data;
    assign in_data[1] = req1_data;

    assign req0_ready = (count[0] != CW'(DEPTH));
    assign req1_ready = (count[1] != CW'(DEPTH));

    assign push[0] = req0_valid && req0_ready;
    assign push[1] = req1_valid && req1_ready;

    assign not_empty[0] = (count[0] != '0);
    assign not_empty[1] = (count[1] != '0);

    // Both non-empty: rr decides. Otherwise the only non-empty FIFO wins.
    assign grant  = (state == IDLE) && !tx_busy && (not_empty != 2'b00);
    assign winner = (not_empty == 2'b11) ? rr : not_empty[1];
    assign head   = mem[winner][rd_ptr[winner]];

    assign pop[0] = grant && !winner;
    assign pop[1] = grant && winner;

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i]] <= in_data[i];
            end
        end
    end

    // The power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
                count[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (push[i]) begin
                    wr_ptr[i] <= wr_ptr[i] + AW'(1);
                end
                if (pop[i]) begin
                    rd_ptr[i] <= rd_ptr[i] + AW'(1);
                end
                if (push[i] && !pop[i]) begin
                    count[i] <= count[i] + CW'(1);
                end else if (!push[i] && pop[i]) begin
                    count[i] <= count[i] - CW'(1);
                end
            end
        end
    end

    // A byte that times out counts as sent and is not re-queued.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rr          <= 1'b0;
            timer       <= '0;
            tx_start    <= 1'b0;
            tx_data     <= 8'h00;
            grant_id    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        tx_data  <= head;
                        grant_id <= winner;
                        tx_start <= 1'b1;
                        rr       <= ~winner;
                        timer    <= '0;
                        state    <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= WAIT_DONE;
                    end else if (timer == TW'(TIMEOUT - 1)) begin
                        timeout_err <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + TW'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a scoreboard of expected grants and a simple transmitter busy model.
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       req0_valid = 1'b0;
    logic [7:0] req0_data = 8'h00;
    logic       req0_ready;
    logic       req1_valid = 1'b0;
    logic [7:0] req1_data = 8'h00;
    logic       req1_ready;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       grant_id;
    logic       timeout_err;

    logic       model_en = 1'b1;
    logic       model_busy = 1'b0;
    logic       force_busy = 1'b0;
    int         busy_left = 0;

    int         compared = 0;
    int         mismatched = 0;
    int         start_count = 0;
    int         starts_before;
    logic [8:0] exp_q [$];
    logic [8:0] exp_entry;

    assign tx_busy = model_busy || force_busy;

    uart_tx_arbiter #(.DEPTH(4), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .tx_busy     (tx_busy),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy rises one cycle after the start pulse and stays high for 10 cycles.
    always @(posedge clk) begin
        if (model_en && tx_start === 1'b1) begin
            model_busy <= 1'b1;
            busy_left  <= 10;
        end else if (busy_left > 0) begin
            busy_left <= busy_left - 1;
            if (busy_left == 1) begin
                model_busy <= 1'b0;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input int src, input logic [7:0] data);
        if (src == 0) begin
            req0_valid = 1'b1;
            req0_data  = data;
        end else begin
            req1_valid = 1'b1;
            req1_data  = data;
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic expectGrant(input logic gid, input logic [7:0] data);
        exp_q.push_back({gid, data});
    endtask

    task automatic drain(input string tag);
        int budget = 400;
        while (exp_q.size() != 0 && budget > 0) begin
            tick();
            budget--;
        end
        checkOutput(tag, exp_q.size(), 0);
        repeat (14) tick();
    endtask

    // Scoreboard monitor: every start pulse must match the oldest expected grant.
    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            start_count++;
            checkOutput("start_busy_low", {31'b0, tx_busy}, 32'd0);
            checkOutput("start_expected", {31'b0, exp_q.size() != 0}, 32'd1);
            if (exp_q.size() != 0) begin
                exp_entry = exp_q.pop_front();
                checkOutput("tx_data", {24'b0, tx_data}, {24'b0, exp_entry[7:0]});
                checkOutput("grant_id", {31'b0, grant_id}, {31'b0, exp_entry[8]});
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        tick();
        doReset();
        $display("[TB] reset values");
        checkOutput("rst_tx_start", {31'b0, tx_start}, 32'd0);
        checkOutput("rst_tx_data", {24'b0, tx_data}, 32'h00);
        checkOutput("rst_grant_id", {31'b0, grant_id}, 32'd0);
        checkOutput("rst_timeout_err", {31'b0, timeout_err}, 32'd0);
        checkOutput("rst_req0_ready", {31'b0, req0_ready}, 32'd1);
        checkOutput("rst_req1_ready", {31'b0, req1_ready}, 32'd1);

        $display("[TB] single byte on req0");
        starts_before = start_count;
        expectGrant(1'b0, 8'hA5);
        applyStimulus(0, 8'hA5);
        checkOutput("lat_no_start_yet", {31'b0, tx_start}, 32'd0);
        checkOutput("t1_req0_ready", {31'b0, req0_ready}, 32'd1);
        tick();
        checkOutput("lat_start", {31'b0, tx_start}, 32'd1);
        drain("t1_drain");
        checkOutput("t1_start_count", start_count - starts_before, 32'd1);
        checkOutput("t1_req0_ready_end", {31'b0, req0_ready}, 32'd1);

        $display("[TB] round robin with preloaded FIFOs");
        doReset();
        force_busy = 1'b1;
        applyStimulus(0, 8'h01);
        applyStimulus(0, 8'h02);
        applyStimulus(1, 8'h11);
        applyStimulus(1, 8'h12);
        expectGrant(1'b0, 8'h01);
        expectGrant(1'b1, 8'h11);
        expectGrant(1'b0, 8'h02);
        expectGrant(1'b1, 8'h12);
        repeat (3) tick();
        checkOutput("t2_wait_foreign_busy", {31'b0, tx_start}, 32'd0);
        force_busy = 1'b0;
        drain("t2_drain");

        $display("[TB] overfill req1 while busy");
        starts_before = start_count;
        force_busy = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            applyStimulus(1, 8'h20 + 8'(i - 1));
            checkOutput($sformatf("t3_ready_after_%0d", i), {31'b0, req1_ready}, {31'b0, (i < 4)});
        end
        for (int i = 0; i < 4; i++) begin
            expectGrant(1'b1, 8'h20 + 8'(i));
        end
        force_busy = 1'b0;
        drain("t3_drain");
        checkOutput("t3_start_count", start_count - starts_before, 32'd4);

        $display("[TB] busy never rises");
        model_en = 1'b0;
        expectGrant(1'b0, 8'h55);
        expectGrant(1'b0, 8'h66);
        applyStimulus(0, 8'h55);
        applyStimulus(0, 8'h66);
        repeat (15) tick();
        checkOutput("t4_err_before", {31'b0, timeout_err}, 32'd0);
        tick();
        checkOutput("t4_err_set", {31'b0, timeout_err}, 32'd1);
        tick();
        checkOutput("t4_next_start", {31'b0, tx_start}, 32'd1);
        repeat (20) tick();
        checkOutput("t4_err_sticky", {31'b0, timeout_err}, 32'd1);
        checkOutput("t4_queue_empty", exp_q.size(), 32'd0);
        model_en = 1'b1;

        $display("[TB] full FIFO with pop and push together");
        force_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 8'hA0 + 8'(i));
            expectGrant(1'b0, 8'hA0 + 8'(i));
        end
        checkOutput("t5_full_ready", {31'b0, req0_ready}, 32'd0);
        force_busy = 1'b0;
        applyStimulus(0, 8'hAF);
        checkOutput("t5_ready_after_pop", {31'b0, req0_ready}, 32'd1);
        drain("t5_drain");

        $display("[TB] reset during WAIT_DONE");
        checkOutput("t6_err_still_set", {31'b0, timeout_err}, 32'd1);
        expectGrant(1'b0, 8'hB0);
        applyStimulus(0, 8'hB0);
        applyStimulus(0, 8'hB1);
        applyStimulus(0, 8'hB2);
        tick();
        checkOutput("t6_busy_before_rst", {31'b0, tx_busy}, 32'd1);
        doReset();
        checkOutput("t6_tx_start", {31'b0, tx_start}, 32'd0);
        checkOutput("t6_tx_data", {24'b0, tx_data}, 32'h00);
        checkOutput("t6_grant_id", {31'b0, grant_id}, 32'd0);
        checkOutput("t6_timeout_err", {31'b0, timeout_err}, 32'd0);
        checkOutput("t6_req0_ready", {31'b0, req0_ready}, 32'd1);
        checkOutput("t6_req1_ready", {31'b0, req1_ready}, 32'd1);
        starts_before = start_count;
        repeat (20) tick();
        checkOutput("t6_no_start", start_count - starts_before, 32'd0);
        expectGrant(1'b0, 8'hC3);
        applyStimulus(0, 8'hC3);
        drain("t6_drain");
        checkOutput("t6_one_start", start_count - starts_before, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART transmitter (uart_send datapath) between two byte sources: requester 0 (local switch/button byte) and requester 1 (echo of bytes from the UART receive path).
- Each requester has a small private FIFO. A round-robin scheduler pops one byte at a time, pulses the transmitter's start input, and tracks its busy signal until the frame completes.
- Sits between the source logic and the uart_send instance inside the top-level UART design.

Parameters:
- DEPTH, 4, entries per requester FIFO (power of two, 2..16)
- TIMEOUT, 16, cycles allowed for tx_busy to rise after tx_start before the grant is abandoned

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous, active-high reset
- req0_valid  input  1  requester 0 offers a byte
- req0_data  input  8  requester 0 byte
- req0_ready  output  1  requester 0 FIFO can accept a byte
- req1_valid  input  1  requester 1 offers a byte
- req1_data  input  8  requester 1 byte
- req1_ready  output  1  requester 1 FIFO can accept a byte
- tx_busy  input  1  transmitter frame in progress
- tx_start  output  1  one-cycle start pulse to transmitter
- tx_data  output  8  byte to transmit, stable from tx_start until next grant
- grant_id  output  1  requester whose byte is on tx_data
- timeout_err  output  1  sticky flag: TIMEOUT expired in WAIT_BUSY; cleared only by rst

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All state is updated on the rising edge of clk.
- Reset values:
  - tx_start=0, tx_data=8'h00, grant_id=0, timeout_err=0
  - both FIFOs empty; state=IDLE; round-robin pointer rr=0
- Reset mid-frame: drops all queued bytes and returns to IDLE. The external transmitter is not aborted.
- FIFO i:
  - reqi_ready = (count_i != DEPTH), derived combinationally from registered count only.
  - Push when reqi_valid && reqi_ready. A valid while not ready is ignored: the byte is lost, no error is flagged, and upstream must hold it.
  - Push and pop in the same cycle: both happen, count unchanged.
  - When full, ready stays 0 even in a pop cycle.
  - Pointers wrap modulo DEPTH. Count width is clog2(DEPTH)+1.
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - If tx_busy=0 and any FIFO is non-empty, pick a winner:
    - If both are non-empty, the winner is rr.
    - Otherwise the winner is the non-empty one.
  - At that edge: pop the winner's head, tx_data<=head, grant_id<=winner, tx_start<=1, rr<=~winner, timer<=0, state->WAIT_BUSY.
  - If tx_busy=1 in IDLE (foreign frame), wait.
- tx_start is high for exactly one cycle, the first cycle in WAIT_BUSY, and is 0 in all other cycles.
- WAIT_BUSY:
  - If tx_busy=1 -> WAIT_DONE.
  - Else timer++. When timer==TIMEOUT-1 with tx_busy still 0: timeout_err<=1, state->IDLE. The byte is considered sent (not re-queued).
- WAIT_DONE: tx_busy=0 -> IDLE. No timeout applies.
- Latency:
  - Push into an empty FIFO with state IDLE and tx_busy=0: push at edge N, tx_start high after edge N+1.
  - Minimum spacing between tx_start pulses is busy duration + 2 cycles.
- Round-robin fairness: with both FIFOs continuously non-empty, grants strictly alternate 0,1,0,1.

Test Plan:
- Reset, then push 8'hA5 on req0 only, tx_busy model rises 1 cycle after start and lasts 10 cycles -> exactly one tx_start pulse, tx_data=8'hA5, grant_id=0, req0_ready stays 1.
- Preload req0 {8'h01,8'h02} and req1 {8'h11,8'h12} before first grant -> tx_data order 01,11,02,12 with grant_id 0,1,0,1; each start only after tx_busy has fallen.
- Push 5 bytes on req1 back-to-back while tx_busy held 1 (DEPTH=4) -> req1_ready=0 after the 4th push, 5th byte not stored; after release, exactly 4 bytes are sent in order.
- tx_busy never asserts after start -> return to IDLE after TIMEOUT=16 cycles, timeout_err=1 and remains 1; next queued byte is then started.
- Full req0 FIFO with pop and valid in the same cycle -> pop occurs, push is rejected (ready=0), count becomes 3, ready=1 next cycle.
- Assert rst for 1 cycle in WAIT_DONE with bytes queued -> next cycle all outputs at reset values, both readys=1, no tx_start until a new push.
